// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment display path
// (scan mux, refresh timer, decoder and the top-level display wrapper).
package ssd_pkg;

  localparam int SSD_N_DIGITS_DEF    = 8;
  localparam int SSD_REFRESH_DIV_DEF = 100000;
  localparam int SSD_BLANK_CYC_DEF   = 1000;

  // Index width never drops to zero, so a single-digit display still has a port.
  function automatic int ssd_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SSD_IDX_W_DEF = ssd_idx_width(SSD_N_DIGITS_DEF);

  typedef logic [SSD_IDX_W_DEF-1:0] digit_idx_t;

  localparam logic [SSD_N_DIGITS_DEF-1:0] ANODE_OFF = {SSD_N_DIGITS_DEF{1'b1}};

endpackage

// File: rtl/ssd_refresh_timer.sv
// Slot/digit scan timer: cnt walks one digit slot, idx walks the digits of a frame.
module ssd_refresh_timer
  import ssd_pkg::*;
#(
  parameter int N_DIGITS    = SSD_N_DIGITS_DEF,
  parameter int REFRESH_DIV = SSD_REFRESH_DIV_DEF,
  parameter int BLANK_CYC   = SSD_BLANK_CYC_DEF,
  localparam int IDX_W      = ssd_idx_width(N_DIGITS),
  localparam int CNT_W      = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx,
  output logic             slot_last,
  output logic             blank,
  output logic             frame_last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_last) begin
      cnt <= '0;
      idx <= frame_last ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // frame_last marks the final digit slot; the frame boundary is slot_last within it.
  assign slot_last  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_last = (idx == IDX_W'(N_DIGITS - 1));
  assign blank      = (cnt < CNT_W'(BLANK_CYC));

endmodule

// File: rtl/ssd_scan_mux.sv
// Double-buffered multi-digit hex scanner feeding the 7-segment decoder.
// Optional leading-zero suppression: define SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int N_DIGITS    = SSD_N_DIGITS_DEF,
  parameter int REFRESH_DIV = SSD_REFRESH_DIV_DEF,
  parameter int BLANK_CYC   = SSD_BLANK_CYC_DEF,
  localparam int IDX_W      = ssd_idx_width(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] din,
  output logic [3:0]            digit_bcd,
  output logic [N_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  update_pending,
  output logic                  frame_tick
);

  logic [IDX_W-1:0]      idx;
  logic                  slot_last;
  logic                  blank;
  logic                  frame_last;
  logic                  boundary;
  logic [4*N_DIGITS-1:0] disp_reg;
  logic [4*N_DIGITS-1:0] pend_reg;
  logic [N_DIGITS-1:0]   an_next;

  ssd_refresh_timer #(
    .N_DIGITS    (N_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx        (idx),
    .slot_last  (slot_last),
    .blank      (blank),
    .frame_last (frame_last)
  );

  assign boundary = slot_last && frame_last;

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lz_mask;

  // Sweep down from the top digit; a digit stays dark while everything above it is zero.
  always_comb begin : lz_scan
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (disp_reg[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end
`endif

  always_comb begin
    an_next = '1;
    if (!blank) an_next[idx] = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    an_next = an_next | lz_mask;
`endif
  end

  // A load on the boundary cycle wins over the older pending value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_reg       <= '0;
      pend_reg       <= '0;
      update_pending <= 1'b0;
      frame_tick     <= 1'b0;
      an_n           <= '1;
      digit_bcd      <= 4'h0;
      digit_idx      <= '0;
    end else begin
      frame_tick <= boundary;
      if (boundary) begin
        if (load)                disp_reg <= din;
        else if (update_pending) disp_reg <= pend_reg;
        update_pending <= 1'b0;
      end else if (load) begin
        pend_reg       <= din;
        update_pending <= 1'b1;
      end
      an_n      <= an_next;
      digit_bcd <= disp_reg[{idx, 2'b00} +: 4];
      digit_idx <= idx;
    end
  end

endmodule
